// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: XNOR tap table and step function used by generator and checker.
// Also holds the checker state type.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } chk_state_t;

  function automatic logic [31:0] tap(input int pos);
    return 32'd1 << (pos - 1);
  endfunction

  // 1-based tap positions from the standard maximal-length XNOR table
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      3:       return tap(3)  | tap(2);
      4:       return tap(4)  | tap(3);
      5:       return tap(5)  | tap(3);
      6:       return tap(6)  | tap(5);
      7:       return tap(7)  | tap(6);
      8:       return tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:       return tap(9)  | tap(5);
      10:      return tap(10) | tap(7);
      11:      return tap(11) | tap(9);
      12:      return tap(12) | tap(6)  | tap(4)  | tap(1);
      13:      return tap(13) | tap(4)  | tap(3)  | tap(1);
      14:      return tap(14) | tap(5)  | tap(3)  | tap(1);
      15:      return tap(15) | tap(14);
      16:      return tap(16) | tap(15) | tap(13) | tap(4);
      17:      return tap(17) | tap(14);
      18:      return tap(18) | tap(11);
      19:      return tap(19) | tap(6)  | tap(2)  | tap(1);
      20:      return tap(20) | tap(17);
      21:      return tap(21) | tap(19);
      22:      return tap(22) | tap(21);
      23:      return tap(23) | tap(18);
      24:      return tap(24) | tap(23) | tap(22) | tap(17);
      25:      return tap(25) | tap(22);
      26:      return tap(26) | tap(6)  | tap(2)  | tap(1);
      27:      return tap(27) | tap(5)  | tap(2)  | tap(1);
      28:      return tap(28) | tap(25);
      29:      return tap(29) | tap(27);
      30:      return tap(30) | tap(6)  | tap(4)  | tap(1);
      31:      return tap(31) | tap(28);
      32:      return tap(32) | tap(22) | tap(2)  | tap(1);
      default: return 32'd0;
    endcase
  endfunction

  // Even tap counts make all-ones a fixed point (the XNOR lock-up state)
  function automatic logic [31:0] lfsr_step(input int width, input logic [31:0] state);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb   = ~(^(state & lfsr_taps(width)));
    return ((state << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-word function of the shared LFSR sequence.
module lfsr_next #(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] cur,
  output logic [NUM_BITS-1:0] nxt
);
  import lfsr_pkg::*;

  assign nxt = NUM_BITS'(lfsr_step(NUM_BITS, 32'(cur)));

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the generator sequence, then flags
// and counts every word that departs from the flywheeled prediction.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEARCH | waiting for a non-all-ones word to seed the prediction
//   ST_VERIFY | counting consecutive correct predictions toward lock
//   ST_LOCKED | locked; prediction free-runs, mispredictions are counted
module lfsr_checker #(
  parameter int NUM_BITS   = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                locked,
  output logic                error,
  output logic [CNT_W-1:0]    err_count
);
  import lfsr_pkg::*;

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int LC_W = $clog2(LOSS_COUNT + 1);
  localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [LC_W-1:0] MISS_LAST  = LC_W'(LOSS_COUNT - 1);

  chk_state_t          state;
  logic [NUM_BITS-1:0] exp_word;
  logic [NUM_BITS-1:0] exp_next;
  logic [NUM_BITS-1:0] data_next;
  logic [MC_W-1:0]     match_cnt;
  logic [LC_W-1:0]     miss_cnt;
  logic                hit;

  lfsr_next #(.NUM_BITS(NUM_BITS)) u_next_exp  (.cur(exp_word), .nxt(exp_next));
  lfsr_next #(.NUM_BITS(NUM_BITS)) u_next_data (.cur(in_data),  .nxt(data_next));

  assign hit = (in_data == exp_word);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_SEARCH;
      exp_word  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      error <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_SEARCH: begin
            if (in_data != '1) begin
              exp_word  <= data_next;
              match_cnt <= '0;
              state     <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (hit) begin
              exp_word  <= exp_next;
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MATCH_LAST) begin
                state    <= ST_LOCKED;
                miss_cnt <= '0;
                locked   <= 1'b1;
              end
            end else begin
              exp_word  <= data_next;
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // never reseed here, so an isolated bad word costs exactly one error
            exp_word <= exp_next;
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              error    <= 1'b1;
              miss_cnt <= miss_cnt + 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (miss_cnt == MISS_LAST) begin
                state  <= ST_SEARCH;
                locked <= 1'b0;
              end
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
      if (clear) err_count <= '0;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed vector table, hand-written corner sequences, and
// randomized streams checked against a behavioural model of the checking rules.
module tb_lfsr_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        locked, error, locked_s, error_s;
  logic [15:0] err_count;
  logic [1:0]  err_count_s;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  lfsr_checker #(.NUM_BITS(8), .LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .locked(locked), .error(error), .err_count(err_count));

  lfsr_checker #(.NUM_BITS(8), .LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .locked(locked_s), .error(error_s), .err_count(err_count_s));

  // Behavioural model: mode 0 = hunting, 1 = confirming, 2 = locked
  int         m_mode, m_match, m_miss, m_cnt16, m_cnt2;
  logic [7:0] m_exp;
  logic       m_locked, m_error;

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    logic fb;
    fb = ~(^(s & 8'hB8));
    return {s[6:0], fb};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_match = 0; m_miss = 0; m_cnt16 = 0; m_cnt2 = 0;
    m_exp = 8'h00; m_locked = 1'b0; m_error = 1'b0;
  endtask

  task automatic model_apply(input logic v, input logic [7:0] d, input logic c);
    m_error = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 8'hFF) begin
          m_exp = ref_step(d); m_match = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_match++;
          m_exp = ref_step(m_exp);
          if (m_match == 4) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_exp = ref_step(d); m_match = 0;
        end
      end else begin
        if (d == m_exp) m_miss = 0;
        else begin
          m_error = 1'b1;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
          m_miss++;
          if (m_miss == 3) m_mode = 0;
        end
        m_exp = ref_step(m_exp);
      end
    end
    if (c) begin m_cnt16 = 0; m_cnt2 = 0; end
    m_locked = (m_mode == 2);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic c);
    in_valid = v; in_data = d; clear = c;
    @(posedge clock);
    #1;
    model_apply(v, d, c);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".error"}, 32'(error), 32'(m_error));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_cnt16));
    chk({tag, ".err_count_sat"}, 32'(err_count_s), 32'(m_cnt2));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    logic       lk;
    logic       er;
    int         cnt;
  } vec_t;

  localparam int N_TBL = 28;
  vec_t tbl [N_TBL];

  initial begin
    logic [7:0] g;
    logic [7:0] d;
    logic       v, c;
    int         k;
    string      pat;

    tbl = '{
      '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0}, '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 0},
      '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 0}, '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 0},
      '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 0}, '{1'b1, 8'h1E, 1'b0, 1'b1, 1'b0, 0},
      '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1}, '{1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 1},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0}, '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1},
      '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2}, '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3},
      '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3}, '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3},
      '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3}, '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3},
      '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 3}, '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 3},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3}, '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3},
      '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 3}, '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 3},
      '{1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 3}, '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 3},
      '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 0}, '{1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 0},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0}, '{1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 0}
    };

    // reset applies without any clock edge
    #1 reset_n = 1'b0;
    #1;
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.err_count", 32'(err_count), 32'd0);
    chk("rst.err_count_sat", 32'(err_count_s), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();

    for (int i = 0; i < N_TBL; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d.locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("tbl%0d.error", i), 32'(error), 32'(tbl[i].er));
      chk($sformatf("tbl%0d.err_count", i), 32'(err_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.err_count_sat", i), 32'(err_count_s),
          32'((tbl[i].cnt > 3) ? 3 : tbl[i].cnt));
    end

    // five errors while staying locked: 2-bit counter saturates at 3
    pat = "mmhmmhm";
    for (int i = 0; i < pat.len(); i++) begin
      if (pat[i] == "m") cycle(1'b1, m_exp ^ 8'h01, 1'b0);
      else cycle(1'b1, m_exp, 1'b0);
      check_model($sformatf("sat%0d", i));
    end
    chk("sat.err_count", 32'(err_count), 32'd5);
    chk("sat.err_count_sat", 32'(err_count_s), 32'd3);
    chk("sat.locked", 32'(locked), 32'd1);

    // asynchronous reset mid-run while locked
    in_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("midrst.locked", 32'(locked), 32'd0);
    chk("midrst.err_count", 32'(err_count), 32'd0);
    chk("midrst.err_count_sat", 32'(err_count_s), 32'd0);
    @(posedge clock); #3;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 8'h00 : ((8'h01 << i) - 8'h01);
      cycle(1'b1, d, 1'b0);
      check_model($sformatf("relock%0d", i));
    end
    chk("relock.locked", 32'(locked), 32'd1);

    // randomized streams with corruption, lock-up words, idles, clears and resyncs
    g = 8'h5A;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 3);
      d = 8'(($urandom));
      if (v) begin
        k = int'($urandom_range(0, 99));
        if (k < 85)      d = g;
        else if (k < 92) d = g ^ 8'(1 << $urandom_range(0, 7));
        else if (k < 95) d = 8'hFF;
        g = ref_step(g);
        if ($urandom_range(0, 99) == 0) begin
          g = 8'(($urandom));
          if (g == 8'hFF) g = 8'h00;
        end
      end
      cycle(v, d, c);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
